// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_slave_responder
// Brief    : Mode-0 SPI slave with oversampled pins, parallel rx port and a
//            one-deep tx buffer. Optional macro SPI_SLAVE_MISO_TRISTATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_responder #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  SPI_CLOCK,
    input  logic                  SPI_SS,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam int                c_cnt_w     = $clog2(DATA_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_word_bits = c_cnt_w'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_ss_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_d;
    logic                    r_ss_d;

    logic [DATA_WIDTH-1:0]   r_tx_shift;
    logic [DATA_WIDTH-1:0]   r_rx_shift;
    logic [DATA_WIDTH-1:0]   r_tx_buf;
    logic                    r_buf_full;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_rx_data;
    logic                    r_rx_valid;
    logic                    r_tx_underrun;
    logic                    r_frame_err;

    logic                    w_sclk;
    logic                    w_ss;
    logic                    w_mosi;
    logic                    w_sclk_rise;
    logic                    w_sclk_fall;
    logic                    w_ss_fall;

    logic                    w_do_load;
    logic                    w_complete;
    logic                    w_abort;
    logic                    w_abort_err;
    logic                    w_sample;
    logic                    w_shift_out;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_CLOCK};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SPI_SS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_sclk_d    <= w_sclk;
            r_ss_d      <= w_ss;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Word completion outranks a deasserted select so a frame that ends right
    // after its last bit is not flagged; SS is tested as a level so that a
    // deassertion landing in LOAD is still seen once SHIFT is entered.
    always_comb begin
        w_state_next = r_state;
        w_do_load    = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_abort_err  = 1'b0;
        w_sample     = 1'b0;
        w_shift_out  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_do_load    = 1'b1;
                w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_bit_cnt == c_word_bits) begin
                    w_complete   = 1'b1;
                    w_state_next = w_ss ? ST_IDLE : ST_LOAD;
                end else if (w_ss) begin
                    w_abort      = 1'b1;
                    w_abort_err  = (r_bit_cnt != '0);
                    w_state_next = ST_IDLE;
                end else if (w_sclk_rise) begin
                    w_sample = 1'b1;
                end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
                    w_shift_out = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_tx_buf      <= '0;
            r_buf_full    <= 1'b0;
            r_bit_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;

            // LOAD looks at the buffer state before any same-cycle write.
            if (w_do_load) begin
                if (r_buf_full) begin
                    r_tx_shift <= r_tx_buf;
                    r_buf_full <= 1'b0;
                end else begin
                    r_tx_shift    <= IDLE_WORD;
                    r_tx_underrun <= 1'b1;
                end
                r_bit_cnt <= '0;
            end
            if (tx_valid && !r_buf_full) begin
                r_tx_buf   <= tx_data;
                r_buf_full <= 1'b1;
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
                r_bit_cnt  <= r_bit_cnt + c_cnt_w'(1);
            end
            if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_complete) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_bit_cnt  <= '0;
                if (w_ss) begin
                    r_tx_shift <= '0;
                end
            end
            if (w_abort) begin
                r_bit_cnt   <= '0;
                r_tx_shift  <= '0;
                r_frame_err <= w_abort_err;
            end
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign SPI_MISO = (r_state == ST_IDLE) ? 1'bz : r_tx_shift[DATA_WIDTH-1];
`else
    assign SPI_MISO = (r_state == ST_IDLE) ? 1'b0 : r_tx_shift[DATA_WIDTH-1];
`endif

    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_responder
// Brief    : Self-checking bench: SPI master model plus transaction-level
//            scoreboard for spi_slave_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_responder;

    localparam int             DW     = 16;
    localparam int             SYNC   = 2;
    localparam int             HALF   = 4;
    localparam logic [DW-1:0]  IDLE_W = 16'h0000;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    localparam logic           MISO_IDLE = 1'bz;
`else
    localparam logic           MISO_IDLE = 1'b0;
`endif

    logic           CLOCK_50  = 1'b0;
    logic           RESET_N   = 1'b0;
    logic           SPI_CLOCK = 1'b0;
    logic           SPI_SS    = 1'b1;
    logic           SPI_MOSI  = 1'b0;
    wire            SPI_MISO;
    logic [DW-1:0]  tx_data   = '0;
    logic           tx_valid  = 1'b0;
    wire            tx_ready;
    wire  [DW-1:0]  rx_data;
    wire            rx_valid;
    wire            tx_underrun;
    wire            frame_err;

    spi_slave_responder #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SYNC),
        .IDLE_WORD   (IDLE_W)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .SPI_CLOCK   (SPI_CLOCK),
        .SPI_SS      (SPI_SS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: expected rx events with the cycle each must appear in.
    typedef struct {
        int            at;
        logic [DW-1:0] d;
    } rxev_t;

    rxev_t          rx_q[$];
    logic [DW-1:0]  pend_q[$];
    logic [DW-1:0]  model_rx = '0;
    int             n_under = 0;
    int             n_ferr  = 0;
    int             n_rxv   = 0;
    int             ss_high_cnt = 0;
    logic [DW-1:0]  mosi_w[4];
    logic [DW-1:0]  cap_w[4];

    always @(negedge CLOCK_50) begin : compare
        bit ev;
        if (RESET_N) begin
            ev = (rx_q.size() > 0) && (rx_q[0].at == cyc);
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, ev});
            if (ev) begin
                model_rx = rx_q[0].d;
                void'(rx_q.pop_front());
            end
            chk("rx_data", {16'd0, rx_data}, {16'd0, model_rx});
            if (rx_valid)    n_rxv++;
            if (tx_underrun) n_under++;
            if (frame_err)   n_ferr++;
            if (SPI_SS) ss_high_cnt++;
            else        ss_high_cnt = 0;
            if (ss_high_cnt > 8) chk("miso_idle", {31'd0, SPI_MISO}, {31'd0, MISO_IDLE});
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic write_tx(input logic [DW-1:0] w);
        int t;
        t = 0;
        while (!tx_ready && t < 200) begin
            tick();
            t++;
        end
        chk("tx_ready_before_write", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", {31'd0, tx_ready}, 32'd0);
        pend_q.push_back(w);
    endtask

    // Low half-period, capture MISO, then raise SCLK.
    task automatic send_bit(input logic b, output logic miso, output int rise_cyc);
        SPI_MOSI = b;
        repeat (HALF) tick();
        miso      = SPI_MISO;
        SPI_CLOCK = 1'b1;
        rise_cyc  = cyc;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit last, output logic [DW-1:0] got);
        int   rc;
        logic m;
        got = '0;
        rc  = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(w[i], m, rc);
            got[i] = m;
            if (i != 0) begin
                repeat (HALF) tick();
                SPI_CLOCK = 1'b0;
            end
        end
        rx_q.push_back('{at: rc + SYNC + 2, d: w});
        if (last) begin
            tick();
            SPI_SS = 1'b1;
            repeat (HALF - 1) tick();
            SPI_CLOCK = 1'b0;
        end else begin
            repeat (HALF) tick();
            SPI_CLOCK = 1'b0;
        end
    endtask

    task automatic frame(input int nw, input bit write2, input logic [DW-1:0] w2);
        int            u0, f0, r0, exp_u;
        logic [DW-1:0] exp_tx;
        u0 = n_under; f0 = n_ferr; r0 = n_rxv; exp_u = 0;
        SPI_SS = 1'b0;
        repeat (HALF) tick();
        chk("tx_ready_after_load", {31'd0, tx_ready}, 32'd1);
        for (int w = 0; w < nw; w++) begin
            if (pend_q.size() > 0) exp_tx = pend_q.pop_front();
            else begin
                exp_tx = IDLE_W;
                exp_u++;
            end
            if (w == 0 && write2) begin
                fork
                    send_word(mosi_w[w], (w == nw - 1), cap_w[w]);
                    begin
                        repeat (20) tick();
                        write_tx(w2);
                    end
                join
            end else begin
                send_word(mosi_w[w], (w == nw - 1), cap_w[w]);
            end
            chk("miso_word", {16'd0, cap_w[w]}, {16'd0, exp_tx});
        end
        repeat (10) tick();
        chk("underrun_count", n_under - u0, exp_u);
        chk("frame_err_count", n_ferr - f0, 0);
        chk("rx_valid_count", n_rxv - r0, nw);
    endtask

    initial begin : stim
        int            u0, f0, r0, rc;
        logic          m;
        logic [DW-1:0] part;

        repeat (3) tick();
        chk("reset_tx_ready",  {31'd0, tx_ready},    32'd1);
        chk("reset_rx_data",   {16'd0, rx_data},     32'd0);
        chk("reset_rx_valid",  {31'd0, rx_valid},    32'd0);
        chk("reset_underrun",  {31'd0, tx_underrun}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err},   32'd0);
        chk("reset_miso",      {31'd0, SPI_MISO},    {31'd0, MISO_IDLE});
        RESET_N = 1'b1;
        repeat (12) tick();

        // Single word with a preloaded reply
        write_tx(16'hA55A);
        mosi_w[0] = 16'h1234;
        frame(1, 1'b0, '0);
        chk("t1_captured", {16'd0, cap_w[0]}, 32'h0000A55A);
        chk("t1_rx_data",  {16'd0, rx_data},  32'h00001234);

        // Empty buffer: idle word goes out
        mosi_w[0] = 16'hFFFF;
        frame(1, 1'b0, '0);
        chk("t2_captured", {16'd0, cap_w[0]}, 32'h00000000);
        chk("t2_rx_data",  {16'd0, rx_data},  32'h0000FFFF);

        // Back-to-back words, second reply written during the first word
        write_tx(16'h0001);
        mosi_w[0] = 16'hBEEF;
        mosi_w[1] = 16'hCAFE;
        frame(2, 1'b1, 16'h0002);
        chk("t3_captured0", {16'd0, cap_w[0]}, 32'h00000001);
        chk("t3_captured1", {16'd0, cap_w[1]}, 32'h00000002);
        chk("t3_rx_data",   {16'd0, rx_data},  32'h0000CAFE);

        // Select dropped after 7 bits
        u0 = n_under; f0 = n_ferr; r0 = n_rxv;
        part = 16'h5555;
        SPI_SS = 1'b0;
        repeat (HALF) tick();
        for (int i = DW - 1; i >= DW - 7; i--) begin
            send_bit(part[i], m, rc);
            repeat (HALF) tick();
            SPI_CLOCK = 1'b0;
        end
        repeat (HALF) tick();
        SPI_SS = 1'b1;
        repeat (12) tick();
        chk("t4_frame_err_pulses", n_ferr - f0, 1);
        chk("t4_underrun_pulses",  n_under - u0, 1);
        chk("t4_no_rx_valid",      n_rxv - r0, 0);
        chk("t4_rx_data_held",     {16'd0, rx_data}, 32'h0000CAFE);
        mosi_w[0] = 16'h00FF;
        frame(1, 1'b0, '0);
        chk("t4_rx_data_next", {16'd0, rx_data}, 32'h000000FF);

        // Reset in the middle of a word, with a reply waiting in the buffer
        part = 16'h1357;
        SPI_SS = 1'b0;
        repeat (HALF) tick();
        write_tx(16'h1111);
        for (int i = DW - 1; i >= DW - 9; i--) begin
            send_bit(part[i], m, rc);
            repeat (HALF) tick();
            SPI_CLOCK = 1'b0;
        end
        send_bit(part[DW-10], m, rc);
        tick();
        tick();
        RESET_N = 1'b0;
        pend_q.delete();
        rx_q.delete();
        model_rx = '0;
        #1;
        chk("t5_tx_ready",  {31'd0, tx_ready},    32'd1);
        chk("t5_rx_data",   {16'd0, rx_data},     32'd0);
        chk("t5_rx_valid",  {31'd0, rx_valid},    32'd0);
        chk("t5_underrun",  {31'd0, tx_underrun}, 32'd0);
        chk("t5_frame_err", {31'd0, frame_err},   32'd0);
        chk("t5_miso",      {31'd0, SPI_MISO},    {31'd0, MISO_IDLE});
        SPI_SS    = 1'b1;
        SPI_CLOCK = 1'b0;
        repeat (4) tick();
        RESET_N = 1'b1;
        repeat (12) tick();
        mosi_w[0] = 16'h8001;
        frame(1, 1'b0, '0);
        chk("t5_rx_after", {16'd0, rx_data},  32'h00008001);
        chk("t5_captured", {16'd0, cap_w[0]}, 32'h00000000);

        // Randomised frames
        for (int r = 0; r < 6; r++) begin
            int nw;
            bit w2;
            nw = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) write_tx(DW'($urandom));
            for (int k = 0; k < nw; k++) mosi_w[k] = DW'($urandom);
            w2 = (nw > 1) && ($urandom_range(0, 1) == 1);
            frame(nw, w2, DW'($urandom));
            repeat ($urandom_range(2, 10)) tick();
        end

        chk("rx_queue_drained", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
